// File: rtl/interp_pkg.sv
// Shared types and constants for the interpolation datapath sequencer.
package interp_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        STOPPING,
        DRAIN
    } state_t;

    localparam int NCH_DEF = 8;

endpackage

// File: rtl/rate_divider.sv
// Loadable modulo-rate phase counter; tick marks phase 0 while enabled.
module rate_divider #(
    parameter int RATE_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              clr,
    input  logic              en,
    input  logic [RATE_W-1:0] rate,
    output logic              tick
);

    logic [RATE_W-1:0] rate_q;
    logic [RATE_W-1:0] phase;
    logic [RATE_W-1:0] rate_eff;

    assign rate_eff = (rate == '0) ? RATE_W'(1) : rate;

    // The load cycle itself plays the role of phase 0, so the counter resumes at 1.
    always_ff @(posedge clk) begin
        if (rst) begin
            rate_q <= RATE_W'(1);
            phase  <= '0;
        end else if (load) begin
            rate_q <= rate_eff;
            phase  <= (rate_eff == RATE_W'(1)) ? '0 : RATE_W'(1);
        end else if (clr) begin
            phase  <= '0;
        end else if (en) begin
            phase  <= (phase == rate_q - RATE_W'(1)) ? '0 : phase + RATE_W'(1);
        end
    end

    assign tick = en & (phase == '0);

endmodule

// File: rtl/interp_ctrl.sv
// Sequencer for the multi-channel interpolation datapath: input cadence,
// all-channel handshake, output alignment and start/stop/drain control.
module interp_ctrl
    import interp_pkg::*;
#(
    parameter int NCH       = NCH_DEF,
    parameter int RATE_W    = 4,
    parameter int DRAIN_CYC = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    input  logic [RATE_W-1:0] rate,
    input  logic [NCH-1:0]    s_tready,
    input  logic [NCH-1:0]    m_tvalid,
    output logic              s_tvalid,
    output logic              out_valid,
    output logic              busy,
    output logic              done,
    output logic              align_err,
    output logic              overrun_err,
    output logic [31:0]       in_count,
    output logic [31:0]       out_count
);

    localparam int DC_W = $clog2(DRAIN_CYC + 1);

    state_t          state, state_nxt;
    logic            start_acc, stop_acc, accept, pending;
    logic            tick, tick_eff, drain_end;
    logic            all_vld_p0, mis_vld_p0;
    logic [DC_W-1:0] idle_cnt;

    assign start_acc = start & (state == IDLE);
    assign stop_acc  = stop & (state == RUN);
    assign accept    = s_tvalid & (&s_tready);
    assign pending   = s_tvalid & ~accept;
    assign tick_eff  = tick & ~stop_acc;
    assign drain_end = (state == DRAIN) & ~out_valid & (idle_cnt == DC_W'(DRAIN_CYC - 1));
    assign busy      = (state != IDLE);

    rate_divider #(
        .RATE_W (RATE_W)
    ) u_div (
        .clk  (clk),
        .rst  (rst),
        .load (start_acc),
        .clr  (stop_acc),
        .en   (state == RUN),
        .rate (rate),
        .tick (tick)
    );

    // A stop whose sample is accepted in the same cycle has nothing left to wait for.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (start)     state_nxt = RUN;
            RUN:      if (stop)      state_nxt = pending ? STOPPING : DRAIN;
            STOPPING: if (accept)    state_nxt = DRAIN;
            DRAIN:    if (drain_end) state_nxt = IDLE;
            default:                 state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            s_tvalid    <= 1'b0;
            overrun_err <= 1'b0;
            in_count    <= '0;
            idle_cnt    <= '0;
            done        <= 1'b0;
        end else begin
            state <= state_nxt;
            done  <= drain_end;

            if (start_acc || tick_eff) s_tvalid <= 1'b1;
            else if (accept)           s_tvalid <= 1'b0;

            if (start_acc)               overrun_err <= 1'b0;
            else if (tick_eff && pending) overrun_err <= 1'b1;

            if (start_acc)   in_count <= '0;
            else if (accept) in_count <= in_count + 32'd1;

            if (state != DRAIN || out_valid) idle_cnt <= '0;
            else                             idle_cnt <= idle_cnt + DC_W'(1);
        end
    end

    // ---- stage p0 -> p1: output valid combine ----
    assign all_vld_p0 = &m_tvalid;
    assign mis_vld_p0 = (|m_tvalid) & ~all_vld_p0;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            align_err <= 1'b0;
            out_count <= '0;
        end else begin
            out_valid <= all_vld_p0;
            if (start_acc) begin
                align_err <= 1'b0;
                out_count <= '0;
            end else begin
                align_err <= align_err | mis_vld_p0;
                if (all_vld_p0) out_count <= out_count + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_interp_ctrl.sv
// Self-checking bench for interp_ctrl: cadence, handshake hold, stop/drain,
// output combine and reset abort.
module tb_interp_ctrl;

    localparam int NCH       = 8;
    localparam int RATE_W    = 4;
    localparam int DRAIN_CYC = 64;
    localparam logic [NCH-1:0] ALL = '1;

    logic              clk;
    logic              rst;
    logic              start;
    logic              stop;
    logic [RATE_W-1:0] rate;
    logic [NCH-1:0]    s_tready;
    logic [NCH-1:0]    m_tvalid;
    logic              s_tvalid;
    logic              out_valid;
    logic              busy;
    logic              done;
    logic              align_err;
    logic              overrun_err;
    logic [31:0]       in_count;
    logic [31:0]       out_count;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        ov;
        logic        ae;
        logic [31:0] cnt;
    } exp_t;
    exp_t sb_q[$];

    interp_ctrl #(
        .NCH       (NCH),
        .RATE_W    (RATE_W),
        .DRAIN_CYC (DRAIN_CYC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .stop        (stop),
        .rate        (rate),
        .s_tready    (s_tready),
        .m_tvalid    (m_tvalid),
        .s_tvalid    (s_tvalid),
        .out_valid   (out_valid),
        .busy        (busy),
        .done        (done),
        .align_err   (align_err),
        .overrun_err (overrun_err),
        .in_count    (in_count),
        .out_count   (out_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected normal completion");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input logic [RATE_W-1:0] r);
        rate  = r;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // Called on the first DRAIN cycle with m_tvalid idle.
    task automatic finish_run(input string name);
        bit seen = 0;
        for (int k = 0; k <= 300 && !seen; k++) begin
            if (done === 1'b1) begin
                seen = 1;
                checks++;
                if (k != DRAIN_CYC || busy !== 1'b0) begin
                    errors++;
                    $display("FAIL %s_drain: done at cycle %0d busy=%b, expected cycle %0d busy=0",
                             name, k, busy, DRAIN_CYC);
                end
            end
            step();
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL %s_timeout: done never pulsed, expected pulse after %0d cycles", name, DRAIN_CYC);
        end else if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_after_done: done=%b busy=%b, expected 0 0", name, done, busy);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) step();
        checks++;
        if ({s_tvalid, out_valid, busy, done, align_err, overrun_err} !== 6'b0 ||
            in_count !== 32'd0 || out_count !== 32'd0) begin
            errors++;
            $display("FAIL reset_values: flags=%b in=%0d out=%0d, expected 000000 0 0",
                     {s_tvalid, out_valid, busy, done, align_err, overrun_err}, in_count, out_count);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_rate4();
        s_tready = ALL;
        pulse_start(4'd4);
        for (int i = 0; i < 40; i++) begin
            checks++;
            if (s_tvalid !== (i % 4 == 0)) begin
                errors++;
                $display("FAIL rate4_cadence: cycle %0d s_tvalid=%b, expected %b", i, s_tvalid, (i % 4 == 0));
            end
            if (i == 39) stop = 1'b1;
            step();
            stop = 1'b0;
        end
        checks++;
        if (in_count !== 32'd10 || s_tvalid !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL rate4_stop: in=%0d s_tvalid=%b busy=%b, expected 10 0 1", in_count, s_tvalid, busy);
        end
        finish_run("rate4");
        checks++;
        if (in_count !== 32'd10) begin
            errors++;
            $display("FAIL rate4_final_count: in=%0d, expected 10", in_count);
        end
    endtask

    task automatic test_rate0();
        s_tready = ALL;
        pulse_start(4'd0);
        for (int i = 0; i < 12; i++) begin
            checks++;
            if (s_tvalid !== 1'b1 || in_count !== 32'(i)) begin
                errors++;
                $display("FAIL rate0_stream: cycle %0d s_tvalid=%b in=%0d, expected 1 %0d", i, s_tvalid, in_count, i);
            end
            step();
        end
        checks++;
        if (overrun_err !== 1'b0) begin
            errors++;
            $display("FAIL rate0_overrun: overrun_err=%b, expected 0", overrun_err);
        end
        stop = 1'b1;
        step();
        stop = 1'b0;
        checks++;
        if (s_tvalid !== 1'b0 || in_count !== 32'd13) begin
            errors++;
            $display("FAIL rate0_stop: s_tvalid=%b in=%0d, expected 0 13", s_tvalid, in_count);
        end
        finish_run("rate0");
    endtask

    task automatic test_hold();
        s_tready = ALL;
        pulse_start(4'd2);
        step();
        step();
        s_tready[3] = 1'b0;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (s_tvalid !== 1'b1 || in_count !== 32'd1) begin
                errors++;
                $display("FAIL hold_pending: hold cycle %0d s_tvalid=%b in=%0d, expected 1 1", i, s_tvalid, in_count);
            end
            step();
        end
        s_tready = ALL;
        step();
        checks++;
        if (in_count !== 32'd2 || overrun_err !== 1'b1 || s_tvalid !== 1'b1) begin
            errors++;
            $display("FAIL hold_release: in=%0d overrun=%b s_tvalid=%b, expected 2 1 1", in_count, overrun_err, s_tvalid);
        end
        step();
        checks++;
        if (in_count !== 32'd3 || s_tvalid !== 1'b0) begin
            errors++;
            $display("FAIL hold_next: in=%0d s_tvalid=%b, expected 3 0", in_count, s_tvalid);
        end
        stop = 1'b1;
        step();
        stop = 1'b0;
        checks++;
        if (s_tvalid !== 1'b0 || in_count !== 32'd3 || overrun_err !== 1'b1) begin
            errors++;
            $display("FAIL hold_stop: s_tvalid=%b in=%0d overrun=%b, expected 0 3 1", s_tvalid, in_count, overrun_err);
        end
        finish_run("hold");
    endtask

    task automatic test_stopping();
        s_tready = ALL;
        pulse_start(4'd3);
        s_tready = '0;
        stop     = 1'b1;
        step();
        stop = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (s_tvalid !== 1'b1 || in_count !== 32'd0 || busy !== 1'b1) begin
                errors++;
                $display("FAIL stopping_wait: cycle %0d s_tvalid=%b in=%0d busy=%b, expected 1 0 1",
                         i, s_tvalid, in_count, busy);
            end
            step();
        end
        s_tready = ALL;
        step();
        checks++;
        if (s_tvalid !== 1'b0 || in_count !== 32'd1 || overrun_err !== 1'b0) begin
            errors++;
            $display("FAIL stopping_accept: s_tvalid=%b in=%0d overrun=%b, expected 0 1 0",
                     s_tvalid, in_count, overrun_err);
        end
        finish_run("stopping");
        checks++;
        if (in_count !== 32'd1) begin
            errors++;
            $display("FAIL stopping_final_count: in=%0d, expected 1", in_count);
        end
    endtask

    task automatic test_combine();
        logic [NCH-1:0] pat [6];
        logic           ae_m;
        logic [31:0]    cnt_m;
        exp_t           e;
        exp_t           got;
        pat   = '{8'hFF, 8'hFF, 8'hF7, 8'h00, 8'hFF, 8'h80};
        ae_m  = 1'b0;
        cnt_m = 32'd0;
        checks++;
        if (align_err !== 1'b0 || out_count !== 32'd0) begin
            errors++;
            $display("FAIL combine_initial: align_err=%b out=%0d, expected 0 0", align_err, out_count);
        end
        for (int i = 0; i < 6; i++) begin
            m_tvalid = pat[i];
            ae_m     = ae_m | ((|pat[i]) & ~(&pat[i]));
            cnt_m    = cnt_m + ((&pat[i]) ? 32'd1 : 32'd0);
            e.ov     = &pat[i];
            e.ae     = ae_m;
            e.cnt    = cnt_m;
            sb_q.push_back(e);
            step();
            got = sb_q.pop_front();
            checks++;
            if (out_valid !== got.ov || align_err !== got.ae || out_count !== got.cnt) begin
                errors++;
                $display("FAIL combine_%0d: m=%h out_valid=%b align_err=%b out=%0d, expected %b %b %0d",
                         i, pat[i], out_valid, align_err, out_count, got.ov, got.ae, got.cnt);
            end
        end
        m_tvalid = '0;
        step();
        step();
        checks++;
        if (align_err !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL combine_sticky: align_err=%b out_valid=%b, expected 1 0", align_err, out_valid);
        end
        s_tready = ALL;
        pulse_start(4'd1);
        checks++;
        if (align_err !== 1'b0 || out_count !== 32'd0) begin
            errors++;
            $display("FAIL combine_clear: align_err=%b out=%0d, expected 0 0", align_err, out_count);
        end
        stop = 1'b1;
        step();
        stop = 1'b0;
        finish_run("combine");
    endtask

    task automatic test_reset_midrun();
        s_tready = ALL;
        pulse_start(4'd2);
        s_tready = '0;
        repeat (3) step();
        checks++;
        if (s_tvalid !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL abort_pending: s_tvalid=%b busy=%b, expected 1 1", s_tvalid, busy);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if ({s_tvalid, out_valid, busy, done, align_err, overrun_err} !== 6'b0 ||
            in_count !== 32'd0 || out_count !== 32'd0) begin
            errors++;
            $display("FAIL abort_values: flags=%b in=%0d out=%0d, expected 000000 0 0",
                     {s_tvalid, out_valid, busy, done, align_err, overrun_err}, in_count, out_count);
        end
        step();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_no_done: done=%b busy=%b, expected 0 0", done, busy);
        end
        s_tready = ALL;
        rate     = 4'd1;
        start    = 1'b1;
        stop     = 1'b1;
        step();
        start = 1'b0;
        stop  = 1'b0;
        checks++;
        if (busy !== 1'b1 || s_tvalid !== 1'b1) begin
            errors++;
            $display("FAIL start_stop_together: busy=%b s_tvalid=%b, expected 1 1", busy, s_tvalid);
        end
        step();
        checks++;
        if (busy !== 1'b1 || s_tvalid !== 1'b1 || in_count !== 32'd1) begin
            errors++;
            $display("FAIL start_stop_run: busy=%b s_tvalid=%b in=%0d, expected 1 1 1", busy, s_tvalid, in_count);
        end
        stop = 1'b1;
        step();
        stop = 1'b0;
        finish_run("restart");
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        stop     = 1'b0;
        rate     = '0;
        s_tready = '0;
        m_tvalid = '0;
        test_reset();
        test_rate4();
        test_rate0();
        test_hold();
        test_stopping();
        test_combine();
        test_reset_midrun();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/interp_ctrl.md
# interp_ctrl

Sequencer for the 8-channel interpolation datapath. It generates the shared input-valid strobe at a programmable cadence of one input sample every RATE cycles. It holds that strobe until every filter channel accepts it, and combines the per-channel output valids into one aligned output strobe. It also runs a start/stop/drain sequence, so downstream capture logic knows when the filter pipelines are empty.

## Interface
- NCH, 8, number of filter channels sharing the valid strobe
- RATE_W, 4, width of the rate field
- DRAIN_CYC, 64, consecutive cycles with no aligned output needed to declare the pipeline drained
- clk  in  1  system clock; all logic on the rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  single-cycle pulse that begins a run
- stop  in  1  single-cycle pulse that ends a run
- rate  in  RATE_W  cycles per input sample; captured on accepted start; 0 is treated as 1
- s_tready  in  NCH  per-channel filter input ready
- m_tvalid  in  NCH  per-channel filter output valid
- s_tvalid  out  1  shared filter input valid (registered)
- out_valid  out  1  aligned output strobe (registered)
- busy  out  1  high in RUN, STOPPING and DRAIN
- done  out  1  one-cycle pulse when DRAIN completes
- align_err  out  1  sticky: channel output valids disagreed
- overrun_err  out  1  sticky: a cadence tick arrived while a sample was still pending
- in_count  out  32  accepted input samples this run
- out_count  out  32  aligned output samples this run

## Operation
- States: IDLE, RUN, STOPPING, DRAIN.
- IDLE -> RUN on start. On that edge: latch rate_q = max(rate,1); clear phase, in_count, out_count, align_err, overrun_err.
- RUN: phase counts 0..rate_q-1, then wraps to 0.
  - Tick occurs when phase==0.
  - Tick with no sample pending: set s_tvalid.
  - Tick with a sample still pending: set overrun_err; no duplicate sample; s_tvalid stays high.
- Accept = s_tvalid & (&s_tready).
  - On accept, s_tvalid falls the next cycle, unless a tick occurs in the same cycle, in which case it stays high.
  - On accept, in_count increments.
  - s_tvalid never falls without an accept, except on rst.
- stop in RUN:
  - If s_tvalid is high -> STOPPING. Stay there until accept, then go to DRAIN.
  - If s_tvalid is low -> DRAIN directly.
  - No new ticks are issued after stop.
- DRAIN: the idle counter clears on each out_valid and otherwise increments. When it reaches DRAIN_CYC -> IDLE, with a one-cycle done pulse.
- Ignored inputs:
  - start outside IDLE.
  - stop in IDLE, STOPPING or DRAIN.
  - When start and stop arrive together in IDLE, start wins and stop is ignored.
- Output combine:
  - out_valid <= &m_tvalid. out_count increments on out_valid.
  - align_err sets if (|m_tvalid) & ~(&m_tvalid) in any cycle.
  - Combining is active in every state, so late outputs are counted during DRAIN and IDLE.
- Counters wrap modulo 2^32 without error.
- rate changes while not in IDLE have no effect.

## Timing
- Reset values:
  - state IDLE; s_tvalid, out_valid, busy, done 0.
  - align_err, overrun_err 0; in_count, out_count 0; phase 0.
- Reset mid-run aborts immediately. s_tvalid drops the next cycle and no done pulse is generated.
- First tick: s_tvalid is high on the cycle after the start cycle. Later ticks follow every rate_q cycles while ready stays high.
- rate_q=1 with all ready high: s_tvalid stays continuously high and one sample is accepted per cycle.
- out_valid, align_err and the out_count increment appear 1 cycle after the m_tvalid sample.
- busy rises the cycle after start and falls in the same cycle done pulses.

## Structure
- Shared package interp_pkg: state enum (IDLE, RUN, STOPPING, DRAIN) and the default NCH constant.
- One sub-module, rate_divider: loadable modulo-rate_q phase counter with tick output and synchronous clear.
- The rest (FSM, pending-valid register, combiner, counters) stays in interp_ctrl.

## Test plan
- rate=4, all ready high, start, run 40 cycles, then stop:
  - s_tvalid high 1 of every 4 cycles.
  - in_count=10; drain completes; done pulses once; busy falls.
- rate=0, all ready high:
  - Behaves as rate=1: s_tvalid continuous, in_count increments every cycle.
- rate=2; hold s_tready[3] low for 5 cycles from an assertion:
  - s_tvalid held high throughout; overrun_err=1; no sample lost or duplicated.
  - in_count advances by exactly 1 for that hold.
- stop while s_tvalid is pending with ready low:
  - STOPPING until ready returns; then exactly one accept, then DRAIN.
- m_tvalid=8'hFF then 8'hF7:
  - First cycle: out_valid=1 and out_count increments.
  - Second cycle: out_valid=0 and align_err sets, staying set until the next start.
- rst asserted mid-run with a pending sample:
  - Next cycle all outputs are at reset values, with no done pulse.
  - A start in IDLE arriving together with stop enters RUN.
